// File: rtl/snake_body_ctrl_if.sv
// ---------------------------------------------------------------------------
// snake_body_ctrl_if : step/grow control and segment read bus  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

interface snake_body_ctrl_if;
  logic       MOVE_TICK;
  logic [1:0] DIR_IN;
  logic       GROW;
  logic [4:0] RD_IDX;
  logic [5:0] HEAD_X;
  logic [4:0] HEAD_Y;
  logic [5:0] LENGTH;
  logic [5:0] RD_X;
  logic [4:0] RD_Y;
  logic       RD_VALID;
  logic       UPDATE_DONE;
  logic       DEAD;

  modport master (
    output MOVE_TICK, DIR_IN, GROW, RD_IDX,
    input  HEAD_X, HEAD_Y, LENGTH, RD_X, RD_Y, RD_VALID, UPDATE_DONE, DEAD
  );

  modport slave (
    input  MOVE_TICK, DIR_IN, GROW, RD_IDX,
    output HEAD_X, HEAD_Y, LENGTH, RD_X, RD_Y, RD_VALID, UPDATE_DONE, DEAD
  );
endinterface

`default_nettype wire

// File: rtl/snake_body_ctrl.sv
// ---------------------------------------------------------------------------
// snake_body_ctrl : snake segment buffer, stepping and collision FSM (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module snake_body_ctrl #(
  parameter int MAX_LEN  = 16,
  parameter int X_MAX    = 39,
  parameter int Y_MAX    = 29,
  parameter int INIT_X   = 20,
  parameter int INIT_Y   = 15,
  parameter int INIT_LEN = 4
) (
  input  wire logic           CLK,
  input  wire logic           RESET,
  snake_body_ctrl_if.slave    bus
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_CHECK = 2'd1;
  localparam logic [1:0] c_ST_DEAD  = 2'd2;
  localparam logic [5:0] c_X_MAX    = 6'(X_MAX);
  localparam logic [4:0] c_Y_MAX    = 5'(Y_MAX);
  localparam logic [5:0] c_MAX_LEN  = 6'(MAX_LEN);

  logic [1:0] r_state, w_state_nxt;
  logic [5:0] r_seg_x [MAX_LEN];
  logic [4:0] r_seg_y [MAX_LEN];
  logic [1:0] r_dir, w_dir;
  logic [5:0] r_len;
  logic [4:0] r_k;
  logic       r_grow_pend, r_done;
  logic [5:0] r_rd_x;
  logic [4:0] r_rd_y;
  logic       r_rd_valid;

  logic [5:0] w_nx, w_kx, w_rx;
  logic [4:0] w_ny, w_ky, w_ry;
  logic       w_wall, w_match, w_last;
  logic       w_tick, w_step, w_hit, w_finish;

  // A reversal request would run the head into its own neck; keep heading.
  assign w_dir = ((bus.DIR_IN ^ r_dir) == 2'd2) ? r_dir : bus.DIR_IN;

  always_comb begin
    w_nx   = r_seg_x[0];
    w_ny   = r_seg_y[0];
    w_wall = 1'b0;
    case (w_dir)
      2'd0: begin w_wall = (r_seg_y[0] == 5'd0);     w_ny = r_seg_y[0] - 5'd1; end
      2'd1: begin w_wall = (r_seg_x[0] >= c_X_MAX);  w_nx = r_seg_x[0] + 6'd1; end
      2'd2: begin w_wall = (r_seg_y[0] >= c_Y_MAX);  w_ny = r_seg_y[0] + 5'd1; end
      default: begin w_wall = (r_seg_x[0] == 6'd0);  w_nx = r_seg_x[0] - 6'd1; end
    endcase
  end

  always_comb begin
    w_kx = '0;
    w_ky = '0;
    w_rx = '0;
    w_ry = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (r_k == 5'(i)) begin
        w_kx = r_seg_x[i];
        w_ky = r_seg_y[i];
      end
      if (bus.RD_IDX == 5'(i)) begin
        w_rx = r_seg_x[i];
        w_ry = r_seg_y[i];
      end
    end
  end

  assign w_match = ({1'b0, r_k} < r_len) && (w_kx == r_seg_x[0]) && (w_ky == r_seg_y[0]);
  assign w_last  = ({1'b0, r_k} >= (r_len - 6'd1));

  // FSM: state register
  always_ff @(posedge CLK) begin
    if (!RESET) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (bus.MOVE_TICK) w_state_nxt = w_wall ? c_ST_DEAD : c_ST_CHECK;
      c_ST_CHECK: if (w_match)       w_state_nxt = c_ST_DEAD;
                  else if (w_last)   w_state_nxt = c_ST_IDLE;
      default:                       w_state_nxt = c_ST_DEAD;
    endcase
  end

  // FSM: decoded actions
  always_comb begin
    w_tick   = (r_state == c_ST_IDLE) && bus.MOVE_TICK;
    w_step   = w_tick && !w_wall;
    w_hit    = (r_state == c_ST_CHECK) && w_match;
    w_finish = (r_state == c_ST_CHECK) && !w_match && w_last;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN) begin
          r_seg_x[i] <= 6'(INIT_X - i);
          r_seg_y[i] <= 5'(INIT_Y);
        end else begin
          r_seg_x[i] <= '0;
          r_seg_y[i] <= '0;
        end
      end
    end else if (w_step) begin
      for (int i = 1; i < MAX_LEN; i++) begin
        r_seg_x[i] <= r_seg_x[i-1];
        r_seg_y[i] <= r_seg_y[i-1];
      end
      r_seg_x[0] <= w_nx;
      r_seg_y[0] <= w_ny;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_dir       <= 2'd1;
      r_len       <= 6'(INIT_LEN);
      r_k         <= 5'd1;
      r_grow_pend <= 1'b0;
      r_done      <= 1'b0;
      r_rd_x      <= '0;
      r_rd_y      <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_tick) r_dir <= w_dir;
      if (w_step) begin
        r_k         <= 5'd1;
        r_grow_pend <= 1'b0;
        // The shift has already kept the old tail one slot further down.
        if ((r_grow_pend || bus.GROW) && (r_len < c_MAX_LEN)) r_len <= r_len + 6'd1;
      end else begin
        if (bus.GROW && (r_state != c_ST_DEAD)) r_grow_pend <= 1'b1;
        if (w_finish == 1'b0 && w_hit == 1'b0 && r_state == c_ST_CHECK) r_k <= r_k + 5'd1;
      end
      r_rd_x     <= w_rx;
      r_rd_y     <= w_ry;
      r_rd_valid <= ({1'b0, bus.RD_IDX} < r_len);
    end
  end

  assign bus.HEAD_X      = r_seg_x[0];
  assign bus.HEAD_Y      = r_seg_y[0];
  assign bus.LENGTH      = r_len;
  assign bus.RD_X        = r_rd_x;
  assign bus.RD_Y        = r_rd_y;
  assign bus.RD_VALID    = r_rd_valid;
  assign bus.UPDATE_DONE = r_done;
  assign bus.DEAD        = (r_state == c_ST_DEAD);

endmodule

`default_nettype wire

// File: tb/tb_snake_body_ctrl.sv
// ---------------------------------------------------------------------------
// tb_snake_body_ctrl : directed vector bench for snake_body_ctrl (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_snake_body_ctrl;
  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  snake_body_ctrl_if bus();

  snake_body_ctrl #(
    .MAX_LEN(16), .X_MAX(39), .Y_MAX(29), .INIT_X(20), .INIT_Y(15), .INIT_LEN(4)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct {
    logic       tick;
    logic [1:0] dir;
    logic [4:0] rd_idx;
    logic [5:0] hx;
    logic [4:0] hy;
    logic [5:0] len;
    logic       done;
    logic [5:0] rx;
    logic [4:0] ry;
    logic       rv;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input logic tick, input logic [1:0] dir, input logic [4:0] rd_idx,
                              input logic [5:0] hx, input logic [4:0] hy, input logic [5:0] len,
                              input logic done, input logic [5:0] rx, input logic [4:0] ry,
                              input logic rv);
    vec_t v;
    v.tick = tick; v.dir = dir; v.rd_idx = rd_idx; v.hx = hx; v.hy = hy; v.len = len;
    v.done = done; v.rx = rx; v.ry = ry; v.rv = rv;
    return v;
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input int hx, input int hy, input int len,
                             input int done, input int dead, input int rx, input int ry,
                             input int rv);
    checks++;
    if (bus.HEAD_X != 6'(hx) || bus.HEAD_Y != 5'(hy) || bus.LENGTH != 6'(len) ||
        bus.UPDATE_DONE != 1'(done) || bus.DEAD != 1'(dead) || bus.RD_X != 6'(rx) ||
        bus.RD_Y != 5'(ry) || bus.RD_VALID != 1'(rv)) begin
      errors++;
      $display("FAIL %s: got head=(%0d,%0d) len=%0d done=%0d dead=%0d rd=(%0d,%0d,v%0d) expected head=(%0d,%0d) len=%0d done=%0d dead=%0d rd=(%0d,%0d,v%0d)",
               name, bus.HEAD_X, bus.HEAD_Y, bus.LENGTH, bus.UPDATE_DONE, bus.DEAD,
               bus.RD_X, bus.RD_Y, bus.RD_VALID, hx, hy, len, done, dead, rx, ry, rv);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    bus.MOVE_TICK = 1'b0;
    bus.GROW = 1'b0;
    bus.DIR_IN = 2'd1;
    bus.RD_IDX = 5'd0;
    cyc();
    cyc();
    RESET = 1'b1;
  endtask

  task automatic do_move(input logic [1:0] dir, input logic grow, input string name);
    bit seen = 1'b0;
    bus.MOVE_TICK = 1'b1;
    bus.DIR_IN = dir;
    bus.GROW = grow;
    cyc();
    bus.MOVE_TICK = 1'b0;
    bus.GROW = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (bus.UPDATE_DONE) seen = 1'b1;
      else cyc();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: update_done got 0 expected 1 within 40 cycles", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int done_cnt;
    int dead_at;

    vecs[0]  = mk(1'b0, 2'd1, 5'd0,  6'd20, 5'd15, 6'd4, 1'b0, 6'd20, 5'd15, 1'b1);
    vecs[1]  = mk(1'b1, 2'd1, 5'd3,  6'd21, 5'd15, 6'd4, 1'b0, 6'd17, 5'd15, 1'b1);
    vecs[2]  = mk(1'b0, 2'd1, 5'd3,  6'd21, 5'd15, 6'd4, 1'b0, 6'd18, 5'd15, 1'b1);
    vecs[3]  = mk(1'b0, 2'd1, 5'd1,  6'd21, 5'd15, 6'd4, 1'b0, 6'd20, 5'd15, 1'b1);
    vecs[4]  = mk(1'b0, 2'd1, 5'd31, 6'd21, 5'd15, 6'd4, 1'b1, 6'd0,  5'd0,  1'b0);
    vecs[5]  = mk(1'b1, 2'd3, 5'd0,  6'd22, 5'd15, 6'd4, 1'b0, 6'd21, 5'd15, 1'b1);
    vecs[6]  = mk(1'b1, 2'd2, 5'd2,  6'd22, 5'd15, 6'd4, 1'b0, 6'd20, 5'd15, 1'b1);
    vecs[7]  = mk(1'b0, 2'd1, 5'd16, 6'd22, 5'd15, 6'd4, 1'b0, 6'd0,  5'd0,  1'b0);
    vecs[8]  = mk(1'b0, 2'd1, 5'd3,  6'd22, 5'd15, 6'd4, 1'b1, 6'd19, 5'd15, 1'b1);
    vecs[9]  = mk(1'b1, 2'd0, 5'd0,  6'd22, 5'd14, 6'd4, 1'b0, 6'd22, 5'd15, 1'b1);
    vecs[10] = mk(1'b0, 2'd1, 5'd1,  6'd22, 5'd14, 6'd4, 1'b0, 6'd22, 5'd15, 1'b1);
    vecs[11] = mk(1'b0, 2'd1, 5'd3,  6'd22, 5'd14, 6'd4, 1'b0, 6'd20, 5'd15, 1'b1);
    vecs[12] = mk(1'b0, 2'd1, 5'd0,  6'd22, 5'd14, 6'd4, 1'b1, 6'd22, 5'd14, 1'b1);

    do_reset();
    check_state("reset_values", 20, 15, 4, 0, 0, 0, 0, 0);
    bus.RD_IDX = 5'd4;
    cyc();
    check_val("rd_valid_idx_eq_len", bus.RD_VALID, 0);

    // Step latency, reverse rejection, tick ignored in CHECK, read port
    for (int i = 0; i < 13; i++) begin
      bus.MOVE_TICK = vecs[i].tick;
      bus.DIR_IN = vecs[i].dir;
      bus.RD_IDX = vecs[i].rd_idx;
      cyc();
      bus.MOVE_TICK = 1'b0;
      check_state($sformatf("vec%0d", i), vecs[i].hx, vecs[i].hy, vecs[i].len, vecs[i].done,
                  0, vecs[i].rx, vecs[i].ry, vecs[i].rv);
    end

    // Growth: pending flag, grow on tick edge, saturation at MAX_LEN
    do_reset();
    bus.GROW = 1'b1;
    cyc();
    bus.GROW = 1'b0;
    cyc();
    do_move(2'd1, 1'b0, "grow_move");
    check_val("grow_len", bus.LENGTH, 5);
    bus.RD_IDX = 5'd4;
    cyc();
    check_state("grow_tail", 21, 15, 5, 0, 0, 17, 15, 1);
    do_move(2'd1, 1'b1, "grow_on_tick");
    check_val("grow_tick_len", bus.LENGTH, 6);
    for (int i = 0; i < 10; i++) do_move(2'd1, 1'b1, "grow_fill");
    check_val("len_at_max", bus.LENGTH, 16);
    do_move(2'd1, 1'b1, "grow_full");
    check_val("len_saturated", bus.LENGTH, 16);
    bus.RD_IDX = 5'd15;
    cyc();
    check_state("full_tail", 33, 15, 16, 0, 0, 18, 15, 1);

    // Wall at y=0: dead, frozen, no done, later ticks and grows ignored
    do_reset();
    for (int i = 0; i < 15; i++) do_move(2'd0, 1'b0, "climb");
    check_val("climb_head_y", bus.HEAD_Y, 0);
    bus.MOVE_TICK = 1'b1;
    bus.DIR_IN = 2'd0;
    bus.RD_IDX = 5'd1;
    cyc();
    bus.MOVE_TICK = 1'b0;
    check_val("wall_dead", bus.DEAD, 1);
    done_cnt = 0;
    for (int n = 0; n < 6; n++) begin
      bus.MOVE_TICK = 1'(n % 2);
      bus.GROW = 1'(n % 2);
      bus.DIR_IN = 2'd1;
      if (bus.UPDATE_DONE) done_cnt++;
      cyc();
    end
    bus.MOVE_TICK = 1'b0;
    bus.GROW = 1'b0;
    check_val("wall_no_done", done_cnt, 0);
    check_state("wall_hold", 20, 0, 4, 0, 1, 20, 1, 1);

    // Self collision found at k=4 of a length-5 body
    do_reset();
    do_move(2'd1, 1'b1, "coll_grow");
    do_move(2'd2, 1'b0, "coll_down");
    do_move(2'd3, 1'b0, "coll_left");
    bus.MOVE_TICK = 1'b1;
    bus.DIR_IN = 2'd0;
    cyc();
    bus.MOVE_TICK = 1'b0;
    dead_at = 0;
    done_cnt = 0;
    for (int n = 1; n <= 10; n++) begin
      if (bus.UPDATE_DONE) done_cnt++;
      if (bus.DEAD && dead_at == 0) dead_at = n;
      cyc();
    end
    check_val("coll_dead_cycle", dead_at, 5);
    check_val("coll_no_done", done_cnt, 0);
    check_val("coll_head_x", bus.HEAD_X, 20);
    check_val("coll_head_y", bus.HEAD_Y, 15);

    // Reset in the middle of CHECK
    do_reset();
    bus.MOVE_TICK = 1'b1;
    bus.DIR_IN = 2'd1;
    cyc();
    bus.MOVE_TICK = 1'b0;
    bus.RD_IDX = 5'd2;
    cyc();
    RESET = 1'b0;
    cyc();
    RESET = 1'b1;
    check_state("rst_mid_check", 20, 15, 4, 0, 0, 0, 0, 0);
    done_cnt = 0;
    for (int n = 0; n < 6; n++) begin
      cyc();
      if (bus.UPDATE_DONE) done_cnt++;
    end
    check_val("rst_no_done", done_cnt, 0);
    check_state("rst_segments", 20, 15, 4, 0, 0, 18, 15, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
